// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
//
// SHA-256 message-schedule stage. Software loads the 16 words of a 512-bit
// block (M0..M15) over a simple register bus and writes START. The block then
// streams W_t / K_t for t = 0..NUM_ROUNDS-1 over a valid/ready handshake.
// W_t is produced on the fly in a 16-word sliding window (w_q[0] is W_t,
// w_q[15] is W_{t+15}), so the full 64-word schedule is never stored.
//
// Ports:
//   ACLK, ARST          clock, synchronous active-high reset
//   WRADDR/BYTEEN/WREN/WDATA   register write port (byte enables per byte lane)
//   RDADDR/RDEN/RDATA          register read port, RDATA registered
//   W_OUT/K_OUT/ROUND_IDX      schedule word, round constant and round index
//   OUT_VALID/OUT_READY        output handshake
//   BUSY                       streaming in progress
//   DONE                       sticky, last round accepted
//   IRQ                        DONE && IRQ_ENA, registered (optional)
//
// Register map (offset = ADDR[11:2], block selected by ADDR[15:12]==BASE_SEL):
//   0x00-0x0F M0..M15 (R/W, byte enabled, frozen while BUSY)
//   0x10 CTRL   W: bit0 START, bit1 DONE_CLR, bit2 IRQ_ENA (optional), bit3 ABORT
//   0x11 STATUS RO: bit0 BUSY, bit1 DONE, [13:8] ROUND_IDX
//   0x12 W_OUT  RO
//
// Build option: define SHA256_SCHED_IRQ_EN to add the IRQ port and the
// CTRL.IRQ_ENA bit. Without it CTRL bit2 is ignored and reads 0.
// -----------------------------------------------------------------------------
module sha256_msg_sched #(
    parameter logic [3:0] BASE_SEL   = 4'h5,
    parameter int         NUM_ROUNDS = 64
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    output logic [31:0] W_OUT,
    output logic [31:0] K_OUT,
    output logic [5:0]  ROUND_IDX,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY,
`ifdef SHA256_SCHED_IRQ_EN
    output logic        IRQ,
`endif
    output logic        DONE
);

    localparam logic [9:0] OFF_CTRL   = 10'h010;
    localparam logic [9:0] OFF_STATUS = 10'h011;
    localparam logic [9:0] OFF_WOUT   = 10'h012;
    localparam logic [5:0] LAST_T     = 6'(NUM_ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // small sigma functions of the schedule recurrence
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state_q;
    logic [31:0] m_q [16];
    logic [31:0] m_d [16];
    logic [31:0] w_q [16];
    logic [5:0]  t_q;
    logic [31:0] k_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        irq_ena_q;
`ifdef SHA256_SCHED_IRQ_EN
    logic        irq_q;
`endif

    logic        wr_sel_s;
    logic        rd_sel_s;
    logic [9:0]  wr_off_s;
    logic [9:0]  rd_off_s;
    logic        m_wr_s;
    logic        ctrl_wr_s;
    logic        start_s;
    logic        done_clr_s;
    logic        abort_s;
    logic        accept_s;
    logic [31:0] w_next_s;
    logic [31:0] ctrl_rd_s;
    logic        unused_s;

    // Address bits [1:0] are word-alignment only.
    assign unused_s = ^{WRADDR[1:0], RDADDR[1:0]};

    // Bus decode, handshake and next schedule word
    always_comb begin
        wr_sel_s   = WREN && (WRADDR[15:12] == BASE_SEL);
        rd_sel_s   = RDEN && (RDADDR[15:12] == BASE_SEL);
        wr_off_s   = WRADDR[11:2];
        rd_off_s   = RDADDR[11:2];
        m_wr_s     = wr_sel_s && (wr_off_s[9:4] == 6'h00) && !busy_q;
        ctrl_wr_s  = wr_sel_s && (wr_off_s == OFF_CTRL) && BYTEEN[0];
        // ABORT dominates START when both are written together
        start_s    = ctrl_wr_s && WDATA[0] && !WDATA[3];
        done_clr_s = ctrl_wr_s && WDATA[1];
        abort_s    = ctrl_wr_s && WDATA[3];
        accept_s   = out_valid_q && OUT_READY;
        // W_{t+16} = sig1(W_{t+14}) + W_{t+9} + sig0(W_{t+1}) + W_t
        w_next_s   = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
    end

    // Byte-enabled update of the message registers
    always_comb begin
        m_d = m_q;
        if (m_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (BYTEEN[b]) begin
                    m_d[wr_off_s[3:0]][8*b +: 8] = WDATA[8*b +: 8];
                end else begin
                    m_d[wr_off_s[3:0]][8*b +: 8] = m_q[wr_off_s[3:0]][8*b +: 8];
                end
            end
        end else begin
            m_d = m_q;
        end
    end

    // CTRL readback: only IRQ_ENA is readable, and only when it exists
    always_comb begin
`ifdef SHA256_SCHED_IRQ_EN
        ctrl_rd_s = {29'd0, irq_ena_q, 2'd0};
`else
        ctrl_rd_s = 32'd0;
`endif
    end

    // Read mux; RDATA only loads on a selected read
    always_comb begin
        rdata_d = rdata_q;
        if (rd_sel_s) begin
            if (rd_off_s[9:4] == 6'h00) begin
                rdata_d = m_q[rd_off_s[3:0]];
            end else if (rd_off_s == OFF_CTRL) begin
                rdata_d = ctrl_rd_s;
            end else if (rd_off_s == OFF_STATUS) begin
                rdata_d = {18'd0, t_q, 6'd0, done_q, busy_q};
            end else if (rd_off_s == OFF_WOUT) begin
                rdata_d = w_q[0];
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registers, streaming FSM and sliding schedule window
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q     <= ST_IDLE;
            for (int k = 0; k < 16; k++) begin
                m_q[k] <= 32'd0;
                w_q[k] <= 32'd0;
            end
            t_q         <= 6'd0;
            k_q         <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'd0;
            irq_ena_q   <= 1'b0;
`ifdef SHA256_SCHED_IRQ_EN
            irq_q       <= 1'b0;
`endif
        end else begin
            m_q     <= m_d;
            rdata_q <= rdata_d;
`ifdef SHA256_SCHED_IRQ_EN
            if (ctrl_wr_s) begin
                irq_ena_q <= WDATA[2];
            end else begin
                irq_ena_q <= irq_ena_q;
            end
            irq_q <= done_q && irq_ena_q;
`else
            irq_ena_q <= 1'b0;
`endif
            // later assignments below (START, last accept) take precedence
            if (done_clr_s) begin
                done_q <= 1'b0;
            end else begin
                done_q <= done_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q     <= ST_RUN;
                        for (int k = 0; k < 16; k++) begin
                            w_q[k] <= m_q[k];
                        end
                        t_q         <= 6'd0;
                        k_q         <= K_ROM[0];
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (accept_s) begin
                        for (int k = 0; k < 15; k++) begin
                            w_q[k] <= w_q[k+1];
                        end
                        w_q[15] <= w_next_s;
                        if (t_q == LAST_T) begin
                            // t stays at the last index; the next START resets it
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            t_q <= t_q + 6'd1;
                            k_q <= K_ROM[t_q + 6'd1];
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign RDATA     = rdata_q;
    assign W_OUT     = w_q[0];
    assign K_OUT     = k_q;
    assign ROUND_IDX = t_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
`ifdef SHA256_SCHED_IRQ_EN
    assign IRQ       = irq_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: register vector table, random
// blocks against a full 64-word schedule model, and hand-written sequences
// for backpressure, busy writes, ABORT and mid-stream reset.
module tb_sha256_msg_sched;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;
    logic [31:0] W_OUT;
    logic [31:0] K_OUT;
    logic [5:0]  ROUND_IDX;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        BUSY;
    logic        DONE;
`ifdef SHA256_SCHED_IRQ_EN
    logic        IRQ;
`endif

    sha256_msg_sched dut (
        .ACLK(ACLK), .ARST(ARST),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
        .W_OUT(W_OUT), .K_OUT(K_OUT), .ROUND_IDX(ROUND_IDX),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .BUSY(BUSY),
`ifdef SHA256_SCHED_IRQ_EN
        .IRQ(IRQ),
`endif
        .DONE(DONE)
    );

    always #5 ACLK = ~ACLK;

    localparam logic [15:0] A_CTRL   = 16'h5040;
    localparam logic [15:0] A_STATUS = 16'h5044;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    vec [15];
    logic [31:0] m_ref [16];
    logic [31:0] w_ref [64];
    logic [31:0] cap_w [64];
    logic [31:0] rd_val;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full schedule computed straight from the recurrence over a 64-word array.
    function automatic void build_w();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w_ref[t] = m_ref[t];
            end else begin
                w_ref[t] = (rotr(w_ref[t-2], 17) ^ rotr(w_ref[t-2], 19) ^ (w_ref[t-2] >> 10))
                         + w_ref[t-7]
                         + (rotr(w_ref[t-15], 7) ^ rotr(w_ref[t-15], 18) ^ (w_ref[t-15] >> 3))
                         + w_ref[t-16];
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge ACLK);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        @(negedge ACLK);
        WREN = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge ACLK);
        RDADDR = a; RDEN = 1'b1;
        @(negedge ACLK);
        RDEN = 1'b0;
        d = RDATA;
    endtask

    task automatic load_block();
        for (int k = 0; k < 16; k++) begin
            wr(16'h5000 + 16'(k * 4), m_ref[k], 4'hF);
        end
        build_w();
    endtask

    // Streams beats first..upto-1 from a negedge; returns at the negedge after
    // the last accepting edge. Cycle-bounded so a stuck DUT cannot hang it.
    task automatic stream(input int first, input int upto, input int pct);
        int t = first;
        int cyc = 0;
        while (t < upto && cyc < 4000) begin
            chk("out_valid", {31'd0, OUT_VALID}, 32'd1);
            if (OUT_VALID !== 1'b1) break;
            chk($sformatf("w_out[%0d]", t), W_OUT, w_ref[t]);
            chk($sformatf("k_out[%0d]", t), K_OUT, K_TAB[t]);
            chk("round_idx", {26'd0, ROUND_IDX}, 32'(t));
            cap_w[t] = W_OUT;
            OUT_READY = ($urandom_range(99) < pct);
            @(posedge ACLK);
            if (OUT_READY) t++;
            @(negedge ACLK);
            cyc++;
        end
        OUT_READY = 1'b0;
        chk("beat_count", 32'(t), 32'(upto));
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_done"}, {31'd0, DONE}, {31'd0, exp_done});
    endtask

    initial begin
        ARST = 1'b1; WRADDR = 16'd0; BYTEEN = 4'd0; WREN = 1'b0; WDATA = 32'd0;
        RDADDR = 16'd0; RDEN = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(negedge ACLK);
        ARST = 1'b0;

        // reset state
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_w_out", W_OUT, 32'd0);
        chk("rst_k_out", K_OUT, 32'd0);
        chk("rst_round_idx", {26'd0, ROUND_IDX}, 32'd0);
        chk_idle("rst", 1'b0);

        // register access vectors
        vec[0]  = '{1'b1, 16'h5000, 4'hF, 32'h11111111, 32'h0};
        vec[1]  = '{1'b0, 16'h5000, 4'h0, 32'h0,        32'h11111111};
        vec[2]  = '{1'b1, 16'h5008, 4'hF, 32'h00000000, 32'h0};
        vec[3]  = '{1'b1, 16'h5008, 4'h5, 32'hAABBCCDD, 32'h0};
        vec[4]  = '{1'b0, 16'h5008, 4'h0, 32'h0,        32'h00BB00DD};
        vec[5]  = '{1'b1, 16'h600C, 4'hF, 32'hDEADBEEF, 32'h0};
        vec[6]  = '{1'b0, 16'h500C, 4'h0, 32'h0,        32'h00000000};
        vec[7]  = '{1'b1, 16'h503C, 4'hA, 32'h12345678, 32'h0};
        vec[8]  = '{1'b0, 16'h503C, 4'h0, 32'h0,        32'h12005600};
        vec[9]  = '{1'b0, A_CTRL,   4'h0, 32'h0,        32'h00000000};
        vec[10] = '{1'b1, 16'h504C, 4'hF, 32'hFFFFFFFF, 32'h0};
        vec[11] = '{1'b0, 16'h5008, 4'h0, 32'h0,        32'h00BB00DD};
        vec[12] = '{1'b0, 16'h6000, 4'h0, 32'h0,        32'h00BB00DD};
        vec[13] = '{1'b0, 16'h504C, 4'h0, 32'h0,        32'h00000000};
        vec[14] = '{1'b0, A_STATUS, 4'h0, 32'h0,        32'h00000000};
        for (int i = 0; i < 15; i++) begin
            if (vec[i].wr) begin
                wr(vec[i].addr, vec[i].data, vec[i].be);
            end else begin
                rd(vec[i].addr, rd_val);
                chk($sformatf("reg_vec%0d", i), rd_val, vec[i].exp);
            end
        end

        // random block, random backpressure
        for (int k = 0; k < 16; k++) m_ref[k] = $urandom();
        load_block();
        wr(A_CTRL, 32'h5, 4'hF);
        stream(0, 64, 70);
        chk_idle("rand_end", 1'b1);
        rd(A_STATUS, rd_val);
        chk("status_after_run", rd_val, 32'h00003F02);
`ifdef SHA256_SCHED_IRQ_EN
        chk("irq_rise", {31'd0, IRQ}, 32'd1);
        wr(A_CTRL, 32'h6, 4'hF);
        @(negedge ACLK);
        chk("irq_clear", {31'd0, IRQ}, 32'd0);
`endif
        wr(A_CTRL, 32'h2, 4'hF);
        chk("done_clr", {31'd0, DONE}, 32'd0);

        // "abc" block with a 5-cycle stall at t=3 and a busy write to M5
        for (int k = 0; k < 16; k++) m_ref[k] = 32'd0;
        m_ref[0] = 32'h61626380;
        m_ref[15] = 32'h00000018;
        load_block();
        wr(A_CTRL, 32'h1, 4'hF);
        chk("start_busy", {31'd0, BUSY}, 32'd1);
        stream(0, 3, 100);
        for (int c = 0; c < 5; c++) begin
            chk("stall_w", W_OUT, 32'd0);
            chk("stall_idx", {26'd0, ROUND_IDX}, 32'd3);
            chk("stall_valid", {31'd0, OUT_VALID}, 32'd1);
            if (c == 1) begin
                WRADDR = 16'h5014; WDATA = 32'hFFFFFFFF; BYTEEN = 4'hF; WREN = 1'b1;
            end else begin
                WREN = 1'b0;
            end
            @(negedge ACLK);
        end
        stream(3, 64, 100);
        chk("abc_w0", cap_w[0], 32'h61626380);
        chk("abc_w15", cap_w[15], 32'h00000018);
        chk("abc_w16", cap_w[16], 32'h61626380);
        chk("abc_w17", cap_w[17], 32'h000F0000);
        chk_idle("abc_end", 1'b1);
        rd(16'h5014, rd_val);
        chk("m5_busy_write", rd_val, 32'd0);

        // START ignored in RUN, then START+ABORT aborts at t=10
        wr(A_CTRL, 32'h1, 4'hF);
        chk("restart_done_cleared", {31'd0, DONE}, 32'd0);
        stream(0, 5, 100);
        wr(A_CTRL, 32'h1, 4'hF);
        chk("start_in_run_idx", {26'd0, ROUND_IDX}, 32'd5);
        stream(5, 10, 60);
        wr(A_CTRL, 32'h9, 4'hF);
        chk_idle("abort", 1'b0);
        @(negedge ACLK);
        chk("abort_stays_idle", {31'd0, OUT_VALID}, 32'd0);
        wr(A_CTRL, 32'h1, 4'hF);
        chk("after_abort_w0", W_OUT, 32'h61626380);
        chk("after_abort_idx", {26'd0, ROUND_IDX}, 32'd0);

        // reset in the middle of a stream at t=20
        stream(0, 20, 80);
        ARST = 1'b1;
        @(negedge ACLK);
        ARST = 1'b0;
        chk("arst_w_out", W_OUT, 32'd0);
        chk("arst_k_out", K_OUT, 32'd0);
        chk("arst_round_idx", {26'd0, ROUND_IDX}, 32'd0);
        chk_idle("arst", 1'b0);
        rd(16'h5000, rd_val);
        chk("arst_m0", rd_val, 32'd0);
        for (int k = 0; k < 16; k++) m_ref[k] = 32'd0;
        build_w();
        wr(A_CTRL, 32'h1, 4'hF);
        chk("zero_k0", K_OUT, 32'h428a2f98);
        stream(0, 64, 50);
        chk("zero_w16", cap_w[16], 32'd0);
        chk_idle("zero_end", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
